// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake, optional two-entry
// skid buffer, synchronous flush that leaves a RESET_VAL bubble behind.
//
// state    | meaning
// ---------+-------------------------------------------
// ST_EMPTY | no entry held, OUT_VALID=0
// ST_ONE   | main entry valid
// ST_FULL  | main and skid entries valid (SKID=1 only)
module pipe_stage_elastic #(
   parameter int               WIDTH     = 32,
   parameter bit               SKID      = 1'b1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             FLUSH,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] IN_DATA,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] OUT_DATA,
   output logic [1:0]       COUNT
);

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] m_data;
   logic [WIDTH-1:0] s_data;
   logic             in_fire;
   logic             out_fire;

   assign OUT_VALID = (state != ST_EMPTY);
   assign OUT_DATA  = m_data;
   assign COUNT     = state;

   // With the skid entry, ready is a pure function of held state so the
   // downstream stall never ripples combinationally upstream.
   always_comb begin
      IN_READY = 1'b0;
      if (SKID)
         IN_READY = (state != ST_FULL) && !RST && !FLUSH;
      else
         IN_READY = ((state == ST_EMPTY) || OUT_READY) && !RST && !FLUSH;
   end

   assign in_fire  = IN_VALID && IN_READY;
   assign out_fire = OUT_VALID && OUT_READY;

   always_ff @(posedge CLK) begin
      if (RST || FLUSH) begin
         state  <= ST_EMPTY;
         m_data <= RESET_VAL;
         s_data <= RESET_VAL;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (in_fire) begin
                  m_data <= IN_DATA;
                  state  <= ST_ONE;
               end
            end
            ST_ONE: begin
               if (in_fire && out_fire) begin
                  m_data <= IN_DATA;
               end else if (in_fire && SKID) begin
                  s_data <= IN_DATA;
                  state  <= ST_FULL;
               end else if (out_fire) begin
                  m_data <= RESET_VAL;
                  state  <= ST_EMPTY;
               end
            end
            ST_FULL: begin
               if (out_fire) begin
                  m_data <= s_data;
                  s_data <= RESET_VAL;
                  state  <= ST_ONE;
               end
            end
            default: begin
               state  <= ST_EMPTY;
               m_data <= RESET_VAL;
               s_data <= RESET_VAL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: one SKID=1 and one SKID=0 instance share the
// same stimulus; each is compared every cycle against its own FIFO-queue model.
module tb_pipe_stage_elastic;

   localparam int           W  = 8;
   localparam logic [W-1:0] RV = 8'hE7;

   logic         clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst, flush, in_valid, out_ready;
   logic [W-1:0] in_data;

   logic         rdy1, vld1, rdy0, vld0;
   logic [W-1:0] dat1, dat0;
   logic [1:0]   cnt1, cnt0;

   pipe_stage_elastic #(.WIDTH(W), .SKID(1'b1), .RESET_VAL(RV)) u_skid (
      .CLK(clk), .RST(rst), .FLUSH(flush),
      .IN_VALID(in_valid), .IN_READY(rdy1), .IN_DATA(in_data),
      .OUT_VALID(vld1), .OUT_READY(out_ready), .OUT_DATA(dat1), .COUNT(cnt1)
   );

   pipe_stage_elastic #(.WIDTH(W), .SKID(1'b0), .RESET_VAL(RV)) u_pass (
      .CLK(clk), .RST(rst), .FLUSH(flush),
      .IN_VALID(in_valid), .IN_READY(rdy0), .IN_DATA(in_data),
      .OUT_VALID(vld0), .OUT_READY(out_ready), .OUT_DATA(dat0), .COUNT(cnt0)
   );

   // Reference model: the stage is a FIFO of capacity 2 (skid) or 1 (pass).
   logic [W-1:0] q1[$];
   logic [W-1:0] q0[$];
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit exp_ready(input int sz, input bit skid);
      if (rst || flush) return 1'b0;
      return skid ? (sz < 2) : ((sz == 0) || out_ready);
   endfunction

   // Check at the falling edge, then advance the model on the rising edge.
   task automatic step();
      bit r1, r0;
      @(negedge clk);
      r1 = exp_ready(q1.size(), 1'b1);
      r0 = exp_ready(q0.size(), 1'b0);
      chk("s1_in_ready",  rdy1, r1);
      chk("s1_out_valid", vld1, q1.size() > 0);
      chk("s1_out_data",  dat1, (q1.size() > 0) ? q1[0] : RV);
      chk("s1_count",     cnt1, q1.size());
      chk("s0_in_ready",  rdy0, r0);
      chk("s0_out_valid", vld0, q0.size() > 0);
      chk("s0_out_data",  dat0, (q0.size() > 0) ? q0[0] : RV);
      chk("s0_count",     cnt0, q0.size());
      @(posedge clk);
      if (rst || flush) begin
         q1.delete();
         q0.delete();
      end else begin
         if (q1.size() > 0 && out_ready) void'(q1.pop_front());
         if (in_valid && r1) q1.push_back(in_data);
         if (q0.size() > 0 && out_ready) void'(q0.pop_front());
         if (in_valid && r0) q0.push_back(in_data);
      end
      #1;
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_data = 8'hA5; out_ready = 1'b1;
      @(posedge clk); #1;
      step(); step();
      chk("rst_count", cnt1, 0);
      chk("rst_data",  dat1, RV);
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      chk("rst_release_ready", rdy1, 1);
      step();

      // back-to-back streaming
      out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         in_valid = 1'b1; in_data = W'(i);
         step();
         chk("stream_head", dat1, i);
      end
      in_valid = 1'b0;
      step(); step();

      // stall fills the skid entry, then drains in order
      out_ready = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h10; step();
      in_data = 8'h11; step();
      in_data = 8'h12; step(); step();
      chk("stall_count", cnt1, 2);
      chk("stall_head",  dat1, 8'h10);
      out_ready = 1'b1;
      step(); step();
      in_valid = 1'b0;
      step(); step(); step();

      // flush while full
      out_ready = 1'b0; in_valid = 1'b1;
      in_data = 8'h20; step();
      in_data = 8'h21; step();
      chk("pre_flush_count", cnt1, 2);
      flush = 1'b1; in_data = 8'h22;
      step();
      flush = 1'b0; in_valid = 1'b0;
      chk("flush_count", cnt1, 0);
      chk("flush_valid", vld1, 0);
      chk("flush_data",  dat1, RV);
      out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h23;
      step();
      chk("post_flush_head", dat1, 8'h23);
      in_valid = 1'b0;
      step(); step();

      // pass-through ready in the single-entry stage
      out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h30;
      step();
      in_data = 8'h31;
      #1;
      chk("pass_stall_ready", rdy0, 0);
      step();
      chk("pass_hold_data", dat0, 8'h30);
      out_ready = 1'b1;
      #1;
      chk("pass_go_ready", rdy0, 1);
      step();
      chk("pass_replace_data", dat0, 8'h31);
      in_valid = 1'b0;
      step(); step(); step();

      // randomized traffic
      for (int c = 0; c < 10000; c++) begin
         rst       = ($urandom_range(199) == 0);
         flush     = ($urandom_range(99) < 5);
         in_valid  = ($urandom_range(99) < 65);
         out_ready = ($urandom_range(99) < 60);
         in_data   = W'($urandom);
         step();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      step(); step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipe_stage_elastic.md
# pipe_stage_elastic

Parametrised elastic pipeline-stage register that replaces the fixed free-running stage latches between IF/ID/EX/MEM/WB. It carries an arbitrary-width payload (control + data bundle) with a valid/ready handshake, so a stage can stall without global clock gating. An optional two-entry skid buffer cuts the combinational ready path. A synchronous FLUSH inserts a bubble for branch/jump squash.

## Interface
Parameters:
- WIDTH, 32, payload width in bits (≥1).
- SKID, 1, 1 = two-entry skid buffer with registered IN_READY; 0 = single entry with pass-through ready.
- RESET_VAL, {WIDTH{1'b0}}, payload value loaded on reset, on flush, and into any emptied entry (control bits 0 = NOP bubble).

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- FLUSH  in  1  synchronous squash of all held entries.
- IN_VALID  in  1  upstream payload valid.
- IN_READY  out  1  stage can accept this cycle.
- IN_DATA  in  WIDTH  upstream payload.
- OUT_VALID  out  1  OUT_DATA holds a valid entry.
- OUT_READY  in  1  downstream accepts (low = stall).
- OUT_DATA  out  WIDTH  head-entry payload, driven directly from the main register.
- COUNT  out  2  occupancy, 0..2 (max 1 when SKID=0).

## Operation
- Definitions: in_fire = IN_VALID & IN_READY; out_fire = OUT_VALID & OUT_READY.
- Storage: main entry M (data + valid) and, when SKID=1, skid entry S (data + valid). OUT_VALID = M.valid. OUT_DATA = M.data.
- States are EMPTY (COUNT=0), ONE (COUNT=1) and FULL (COUNT=2, SKID=1 only).
- IN_READY:
  - SKID=1: IN_READY = (state != FULL) & !RST & !FLUSH.
  - SKID=0: IN_READY = (!M.valid | OUT_READY) & !RST & !FLUSH.
- Transitions (no FLUSH):
  - EMPTY, in_fire: M←IN_DATA, go to ONE.
  - ONE, in_fire & out_fire: M←IN_DATA, stay in ONE.
  - ONE, in_fire & !out_fire: S←IN_DATA, go to FULL (SKID=1 only; IN_READY is 0 in this case when SKID=0).
  - ONE, !in_fire & out_fire: M←RESET_VAL, go to EMPTY.
  - FULL, out_fire: M←S.data, S←RESET_VAL, go to ONE. No input is accepted in FULL.
  - Any other case: hold all entries.
- FLUSH=1: next state is EMPTY; M and S are loaded with RESET_VAL. IN_READY is 0, so no input is accepted. An out_fire in the flush cycle counts as delivered; the entry is removed either way.
- RST=1: same effect as FLUSH and takes priority over it.
- Entries leave in strict FIFO order. No entry is duplicated or dropped except by FLUSH or RST.
- Holding rule: while OUT_VALID=1 and OUT_READY=0, OUT_DATA and OUT_VALID stay stable until out_fire.

## Timing
- Values after the first clock edge with RST=1: OUT_VALID=0, OUT_DATA=RESET_VAL, COUNT=0. IN_READY=1 in the first cycle after RST deasserts.
- Latency is 1 cycle from in_fire to OUT_VALID=1 with that payload.
- Throughput is 1 entry/cycle when OUT_READY is held high, in both SKID modes.
- SKID=1: IN_READY depends only on state, RST and FLUSH. There is no combinational path from OUT_READY to IN_READY.
- SKID=0: IN_READY has a combinational path from OUT_READY.
- Stall recovery (SKID=1): when OUT_READY rises with the stage FULL, IN_READY returns to 1 on the next cycle.
- Boundary cases:
  - FULL with IN_VALID=1 and OUT_READY=0: IN_READY=0 and nothing changes.
  - EMPTY with OUT_READY=1 and no input: OUT_VALID stays 0.
  - FLUSH while FULL: EMPTY on the next cycle, and both held entries are lost.
  - RST mid-stall: same as FLUSH.

## Test plan
- Reset: hold RST 2 cycles with IN_VALID=1, IN_DATA=0xA5. Required: no input accepted, OUT_VALID=0, OUT_DATA=RESET_VAL, COUNT=0; IN_READY=1 in the first cycle after release.
- Streaming: SKID=1, OUT_READY=1, send 0x1..0x8 back-to-back. Required: 0x1..0x8 appear on consecutive cycles starting 1 cycle after the first in_fire; COUNT stays ≤1.
- Stall/skid: SKID=1, OUT_READY=0, send 0x10, 0x11, 0x12. Required: 0x10 and 0x11 accepted, then IN_READY=0 and COUNT=2. After OUT_READY=1, output is 0x10, 0x11, 0x12 in order with no loss.
- Flush: SKID=1, stage FULL with 0x20/0x21, pulse FLUSH with IN_VALID=1 and data 0x22. Required: 0x22 not accepted; next cycle OUT_VALID=0, COUNT=0, OUT_DATA=RESET_VAL; the next input streams normally.
- SKID=0 pass-through: stage ONE holding 0x30, IN_VALID=1 with data 0x31. With OUT_READY=1: IN_READY=1, 0x31 replaces 0x30 the next cycle. With OUT_READY=0: IN_READY=0, 0x30 held.
- Random: random IN_VALID/OUT_READY/FLUSH (5%), 10k cycles, both SKID values, against a scoreboard queue. Required: order preserved, no duplicates, losses only at FLUSH, COUNT always equal to the model.
